// File: rtl/long_op_if.sv
// EX-stage long-op handshake between the pipeline (master) and the long-op sequencer (slave).
interface long_op_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             stall;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  stall, result, result_valid, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output stall, result, result_valid, div_zero
  );
endinterface

// File: rtl/long_op_sequencer.sv
// Multi-cycle multiply / unsigned modulo / integer square root beside the single-cycle ALU.
// Holds the pipeline via stall while iterating, then strobes the result for one cycle.
module long_op_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  long_op_if.slave bus
);
  localparam int unsigned HW = WIDTH / 2;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_SQRT = 4'b0101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH+1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dz_q, dz_d;

  logic             long_op;
  logic             mod_by_zero;
  logic [WIDTH-1:0] step_x, step_y, final_val;
  logic [WIDTH+1:0] step_acc;
  logic [WIDTH:0]   mod_sh;
  logic [WIDTH+1:0] sq_sh, sq_trial;

  always_comb begin
    long_op     = bus.start && (bus.op inside {OP_MUL, OP_MOD, OP_SQRT});
    mod_by_zero = (bus.op == OP_MOD) && (bus.b == '0);
  end

  // One iteration of the captured op. x: shifting a/radicand, y: b or root, acc: sum/remainder.
  always_comb begin
    mod_sh    = {acc_q[WIDTH-1:0], x_q[WIDTH-1]};
    sq_sh     = {acc_q[WIDTH-1:0], x_q[WIDTH-1 -: 2]};
    sq_trial  = {y_q, 2'b01};
    step_x    = x_q;
    step_y    = y_q;
    step_acc  = acc_q;
    final_val = acc_q[WIDTH-1:0];
    case (op_q)
      OP_MUL: begin
        step_acc  = {2'b00, acc_q[WIDTH-1:0] + (y_q[0] ? x_q : '0)};
        step_x    = x_q << 1;
        step_y    = y_q >> 1;
        final_val = step_acc[WIDTH-1:0];
      end
      OP_MOD: begin
        step_x = x_q << 1;
        if (mod_sh >= {1'b0, y_q}) step_acc = {1'b0, mod_sh - {1'b0, y_q}};
        else                       step_acc = {1'b0, mod_sh};
        final_val = step_acc[WIDTH-1:0];
      end
      OP_SQRT: begin
        step_x = x_q << 2;
        if (sq_sh >= sq_trial) begin
          step_acc = sq_sh - sq_trial;
          step_y   = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          step_acc = sq_sh;
          step_y   = {y_q[WIDTH-2:0], 1'b0};
        end
        final_val = step_y;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (long_op) state_d = mod_by_zero ? S_DONE : S_RUN;
      S_RUN:   if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result load
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (long_op) begin
          op_d  = bus.op;
          x_d   = bus.a;
          y_d   = (bus.op == OP_SQRT) ? '0 : bus.b;
          acc_d = '0;
          cnt_d = (bus.op == OP_SQRT) ? CW'(HW) : CW'(WIDTH);
          if (mod_by_zero) begin
            cnt_d    = '0;
            result_d = bus.a;
            dz_d     = 1'b1;
          end
        end
      end
      S_RUN: begin
        x_d   = step_x;
        y_d   = step_y;
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = final_val;
          dz_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.stall        = ((state_q == S_IDLE) && long_op) || (state_q == S_RUN);
    bus.result_valid = (state_q == S_DONE);
    bus.result       = result_q;
    bus.div_zero     = dz_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      dz_q     <= dz_d;
    end
  end
endmodule

// File: tb/tb_long_op_sequencer.sv
// Scoreboard bench for long_op_sequencer: directed ops with hand-computed results and latencies.
module tb_long_op_sequencer;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  long_op_if #(.WIDTH(W)) bus ();

  long_op_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         dz;
    int unsigned  lat;
    int unsigned  stl;
    int unsigned  t0;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned stall_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts stall cycles and pops one expectation per result strobe
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      stall_cnt = 0;
    end else begin
      if (bus.stall) stall_cnt++;
      if (bus.result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 64'(bus.result_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("result",   64'(bus.result),   64'(e.res));
          chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
          chk("latency",  64'(cyc - e.t0),   64'(e.lat));
          chk("stall_cycles", 64'(stall_cnt), 64'(e.stl));
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic edz, input int unsigned lat,
                       input bit push, input bit perturb);
    exp_t e;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) begin
      e.res = er; e.dz = edz; e.lat = lat; e.stl = lat; e.t0 = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 4'b0011;
    if (perturb) begin
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h0000_0003;
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.result_valid) seen = 1'b1;
    end
    chk("done_within_bound", 64'(seen), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 4'b0000;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_result",       64'(bus.result),       64'd0);
    chk("reset_result_valid", 64'(bus.result_valid), 64'd0);
    chk("reset_div_zero",     64'(bus.div_zero),     64'd0);
    chk("reset_stall",        64'(bus.stall),        64'd0);

    // mul
    issue(4'b0011, 32'd7, 32'd6, 32'd42, 1'b0, 33, 1'b1, 1'b0);
    wait_done();
    issue(4'b0011, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33, 1'b1, 1'b0);
    wait_done();
    issue(4'b0101, 32'd1000000, 32'd0, 32'd1000, 1'b0, 17, 1'b1, 1'b0);
    wait_done();

    // mod with operands disturbed mid-RUN
    issue(4'b0100, 32'd100, 32'd7, 32'd2, 1'b0, 33, 1'b1, 1'b1);
    wait_done();
    issue(4'b0100, 32'hFFFF_FFFF, 32'h10, 32'hF, 1'b0, 33, 1'b1, 1'b1);
    wait_done();
    issue(4'b0100, 32'd5, 32'd0, 32'd5, 1'b1, 1, 1'b1, 1'b0);
    wait_done();
    issue(4'b0100, 32'd9, 32'd4, 32'd1, 1'b0, 33, 1'b1, 1'b0);
    wait_done();

    // sqrt
    issue(4'b0101, 32'hFFFF_FFFF, 32'd7, 32'd65535, 1'b0, 17, 1'b1, 1'b1);
    wait_done();
    issue(4'b0101, 32'd0, 32'd0, 32'd0, 1'b0, 17, 1'b1, 1'b0);
    wait_done();
    issue(4'b0101, 32'd15, 32'd0, 32'd3, 1'b0, 17, 1'b1, 1'b0);
    wait_done();

    // single-cycle op is ignored
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = 4'b0010;
    bus.a     = 32'd1;
    bus.b     = 32'd2;
    #1 chk("add_no_stall", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("add_no_valid", 64'(bus.result_valid), 64'd0);
    chk("add_idle_stall", 64'(bus.stall), 64'd0);
    repeat (5) @(posedge clk);

    // reset mid-RUN aborts without a strobe
    issue(4'b0011, 32'h1234, 32'h5678, 32'd0, 1'b0, 33, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_result",       64'(bus.result),       64'd0);
    chk("abort_result_valid", 64'(bus.result_valid), 64'd0);
    chk("abort_div_zero",     64'(bus.div_zero),     64'd0);
    chk("abort_stall",        64'(bus.stall),        64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_quiet_valid", 64'(bus.result_valid), 64'd0);

    issue(4'b0011, 32'd3, 32'd3, 32'd9, 1'b0, 33, 1'b1, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/long_op_sequencer.md
# long_op_sequencer

Multi-cycle execution controller for the long ALU operations: multiply (ALU op 4'b0011), unsigned modulo (DIVU, 4'b0100) and integer square root (RSQRT, 4'b0101). It sits beside the single-cycle ALU in the EX stage and is started by the ALU-control op code. It holds the pipeline with a stall signal while iterating, then presents the 32-bit result for exactly one cycle. Single-cycle op codes pass through untouched: no stall, no result.

## Interface

- WIDTH, 32, operand/result width; must be even.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction valid; qualifies op.
- op  in  4  ALU-control op code.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt); ignored for sqrt.
- stall  out  1  hold PC/IF/ID/EX; combinational.
- result  out  WIDTH  long-op result; valid only with result_valid.
- result_valid  out  1  one-cycle result strobe.
- div_zero  out  1  modulo by zero flag; valid with result_valid.

## Operation

- Long op: start=1 and op ∈ {0011, 0100, 0101}. All other op codes are ignored in every state.
- States: IDLE, RUN, DONE.
- IDLE → RUN on a long op. At that edge:
  - capture a, b and op;
  - load the iteration counter: WIDTH for mul and mod, WIDTH/2 for sqrt.
- IDLE → DONE directly for mod with b==0. At that edge: result register = a, div_zero register = 1.
- RUN:
  - one iteration per cycle; counter decrements each cycle;
  - on the edge where the counter goes 1→0, load the final value into the result register and go to DONE.
- DONE → IDLE unconditionally. start in DONE is ignored; the next instruction reaches EX in IDLE.
- Captured operands are used exclusively; changes on a/b/op after acceptance have no effect.
- mul: shift-add over WIDTH bits of b.
  - result = low WIDTH bits of a*b (unsigned);
  - overflow discarded; no flag.
- mod: restoring shift-subtract over WIDTH bits.
  - result = a mod b (unsigned);
  - quotient discarded;
  - div_zero = 0 unless b==0.
- sqrt: digit-by-digit (two radicand bits per iteration).
  - result = floor(sqrt(a)), zero-extended to WIDTH.
- Outputs:
  - result_valid = 1 only in DONE;
  - result and div_zero are registers and hold their last values until the next completion.
- stall = (state==IDLE && long op) || state==RUN. stall is 0 in DONE, so the pipeline advances and captures result in that cycle.
- Reset (rst_n low, at any time including mid-RUN):
  - state = IDLE, counter = 0;
  - result = 0, div_zero = 0, result_valid = 0, captured operands = 0;
  - stall follows its combinational definition: 0 unless start with a long op is present in IDLE.
  - The aborted operation produces no result_valid.

## Timing

- Acceptance edge E0, in the IDLE cycle where the long op is present.
- mul/mod: RUN for WIDTH cycles. result_valid is high in the cycle starting at edge E0+WIDTH+1. Latency is 33 cycles for WIDTH=32.
- sqrt: RUN for WIDTH/2 cycles. result_valid is high at E0+WIDTH/2+1, i.e. 17 cycles.
- Mod by zero: result_valid is high at E0+1.
- stall is high from the acceptance cycle through the last RUN cycle: 33 cycles for mul/mod, 17 for sqrt, 1 for mod by zero.
- Back-to-back long ops: the second is accepted in the IDLE cycle after DONE. There is no overlap and no queuing.

## Test plan

- Mul 7×6:
  - stall high for 33 cycles;
  - result_valid pulses once, 33 cycles after acceptance, with result=42, div_zero=0.
- Mul 0xFFFFFFFF×2 → result=0xFFFFFFFE (truncated). Then back-to-back sqrt 1000000 → result=1000, valid 17 cycles after its acceptance.
- Mod 100 mod 7 → 2; 0xFFFFFFFF mod 0x10 → 0xF. In each case, a/b are changed mid-RUN and the result must be unaffected.
- Mod 5 mod 0:
  - stall high one cycle;
  - next cycle result_valid=1, result=5, div_zero=1;
  - a following mod 9 mod 4 → 1 with div_zero=0.
- Sqrt 0xFFFFFFFF → 65535; sqrt 0 → 0; sqrt 15 → 3.
- Robustness:
  - start with op=0010 (add) → no stall, no result_valid;
  - rst_n pulsed low mid-RUN of a mul → all outputs 0 immediately, state IDLE, no result_valid;
  - a subsequent mul 3×3 → 9 with normal 33-cycle latency.
